// File: rtl/mult_result_checker_if.sv
// Tuple/result bus between the multiplier controller and its result checker.
//   master: drives in_valid, mode, op_a, op_b, dut_product; sees in_ready and results
//   slave : the checker; drives in_ready, done, pass, expected, check_count, err_count
`timescale 1ns/1ps
interface mult_result_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [63:0]      dut_product;
  logic             done;
  logic             pass;
  logic [63:0]      expected;
  logic [CNT_W-1:0] check_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, mode, op_a, op_b, dut_product,
    input  in_ready, done, pass, expected, check_count, err_count
  );

  modport slave (
    input  in_valid, mode, op_a, op_b, dut_product,
    output in_ready, done, pass, expected, check_count, err_count
  );
endinterface

// File: rtl/mult_result_checker.sv
// Golden-model checker for the fast multipliers: recomputes each accepted tuple
// with a one-bit-per-cycle shift-add multiplier and compares all 64 product bits.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - mult_result_checker_if.slave (tuple handshake, result and counters)
// Parameter CNT_W: width of the saturating check/error counters.
// Optional macro CHK_HALT_ON_ERR_EN: stop in HALT after the first mismatch.
`timescale 1ns/1ps
module mult_result_checker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  mult_result_checker_if.slave  bus
);

  localparam int unsigned CW = 6;  // bit counter, holds N up to 32

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] CMP  = 3'd4;
`ifdef CHK_HALT_ON_ERR_EN
  localparam logic [2:0] HALT = 3'd5;
`endif

  // Operand width N for each mode.
  function automatic logic [CW-1:0] n_of(input logic [1:0] m);
    case (m)
      2'd2:    return CW'(16);
      2'd3:    return CW'(32);
      default: return CW'(8);
    endcase
  endfunction

  // Keeps only the low N operand bits.
  function automatic logic [31:0] op_mask(input logic [1:0] m);
    case (m)
      2'd2:    return 32'h0000_FFFF;
      2'd3:    return 32'hFFFF_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

  // Keeps only the low 2N product bits.
  function automatic logic [63:0] prod_mask(input logic [1:0] m);
    case (m)
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      2'd3:    return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'h0000_0000_0000_FFFF;
    endcase
  endfunction

  function automatic logic sign_of(input logic [31:0] v, input logic [1:0] m);
    case (m)
      2'd1:    return v[7];
      2'd2:    return v[15];
      2'd3:    return v[31];
      default: return 1'b0;
    endcase
  endfunction

  // Magnitude of an N-bit operand; negating in 32 bits covers -2^(N-1) for every N.
  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic [1:0] m);
    logic [31:0] s;
    case (m)
      2'd1:    s = {{24{v[7]}}, v[7:0]};
      2'd2:    s = {{16{v[15]}}, v[15:0]};
      default: s = v;
    endcase
    return sign_of(v, m) ? (~s + 32'd1) : s;
  endfunction

  logic [2:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [63:0]      expected_q, expected_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [63:0]      prod_q, prod_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [63:0]      acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             match_c;

  assign match_c = (expected_q == prod_q);

  // State register and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      expected_q <= '0;
      chk_q      <= '0;
      err_q      <= '0;
      mode_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      expected_q <= expected_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    expected_d = expected_q;
    chk_d      = chk_q;
    err_d      = err_q;
    mode_d     = mode_q;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          mode_d  = bus.mode;
          a_d     = bus.op_a & op_mask(bus.mode);
          b_d     = bus.op_b & op_mask(bus.mode);
          prod_d  = bus.dut_product;
          state_d = LOAD;
        end
      end
      LOAD: begin
        neg_d    = sign_of(a_q, mode_q) ^ sign_of(b_q, mode_q);
        mcand_d  = {32'd0, mag_of(a_q, mode_q)};
        mplier_d = mag_of(b_q, mode_q);
        acc_d    = '0;
        cnt_d    = n_of(mode_q);
        state_d  = MUL;
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        expected_d = (neg_q ? (~acc_q + 64'd1) : acc_q) & prod_mask(mode_q);
        state_d    = CMP;
      end
      CMP: begin
        done_d = 1'b1;
        pass_d = match_c;
        if (chk_q != {CNT_W{1'b1}}) chk_d = chk_q + CNT_W'(1);
        if (!match_c && (err_q != {CNT_W{1'b1}})) err_d = err_q + CNT_W'(1);
`ifdef CHK_HALT_ON_ERR_EN
        state_d = match_c ? IDLE : HALT;
`else
        state_d = IDLE;
`endif
      end
`ifdef CHK_HALT_ON_ERR_EN
      HALT: state_d = HALT;  // frozen until reset
`endif
      default: state_d = IDLE;
    endcase

    // Ready returns one cycle after the done pulse, never during it.
    in_ready_d = (state_d == IDLE) && (state_q != CMP);
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.expected    = expected_q;
  assign bus.check_count = chk_q;
  assign bus.err_count   = err_q;

endmodule

// File: tb/tb_mult_result_checker.sv
// Directed self-checking bench for mult_result_checker.
`timescale 1ns/1ps
module tb_mult_result_checker;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  mult_result_checker_if #(.CNT_W(16)) bus ();

  mult_result_checker #(.CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Presents one tuple, waits for its done pulse and checks result, latency and handshake.
  task automatic do_check(input string tag, input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] p,
                          input logic [63:0] exp_e, input logic exp_pass, input int exp_lat,
                          input bit hold, input bit exp_ready_after);
    int lat;
    int ready_seen;
    int waited;
    bus.mode        = m;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.dut_product = p;
    bus.in_valid    = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clock); #1;
      waited++;
    end
    if (waited >= 100) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
    @(posedge clock); #1;  // accept edge
    if (!hold) begin
      // scrambled inputs after accept must not disturb the check in progress
      bus.in_valid    = 1'b0;
      bus.mode        = ~m;
      bus.op_a        = ~a;
      bus.op_b        = ~b;
      bus.dut_product = ~p;
    end
    lat = 0;
    ready_seen = 0;
    while (lat < 60) begin
      @(posedge clock); #1;
      lat++;
      if (bus.done) break;
      if (bus.in_ready) ready_seen++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_ready"}, 64'(ready_seen), 64'd0);
    check({tag, "_pass"}, 64'(bus.pass), 64'(exp_pass));
    check({tag, "_expected"}, bus.expected, exp_e);
    check({tag, "_ready_in_done"}, 64'(bus.in_ready), 64'd0);
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_ready_after"}, 64'(bus.in_ready), 64'(exp_ready_after));
  endtask

  task automatic check_counts(input string tag, input int exp_chk, input int exp_err);
    check({tag, "_check_count"}, 64'(bus.check_count), 64'(exp_chk));
    check({tag, "_err_count"}, 64'(bus.err_count), 64'(exp_err));
  endtask

  initial begin
    int dones;
    int readies;
    checks          = 0;
    failures        = 0;
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.mode        = 2'd0;
    bus.op_a        = 32'd0;
    bus.op_b        = 32'd0;
    bus.dut_product = 64'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_pass", 64'(bus.pass), 64'd0);
    check("rst_expected", bus.expected, 64'd0);
    check_counts("rst", 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // unsigned 8x8 corner
    do_check("u8_ff", 2'd0, 32'h0000_00FF, 32'h0000_00FF, 64'h0000_0000_0000_FE01,
             64'h0000_0000_0000_FE01, 1'b1, 11, 1'b0, 1'b1);
    check_counts("u8_ff", 1, 0);

    // signed 8x8: most-negative operand both sides, then mixed signs
    do_check("s8_mm", 2'd1, 32'h0000_0080, 32'h0000_0080, 64'h0000_0000_0000_4000,
             64'h0000_0000_0000_4000, 1'b1, 11, 1'b0, 1'b1);
    do_check("s8_m1", 2'd1, 32'h0000_0080, 32'h0000_0001, 64'h0000_0000_0000_FF80,
             64'h0000_0000_0000_FF80, 1'b1, 11, 1'b0, 1'b1);
    check_counts("s8", 3, 0);

    // signed 32x32: -1 * 2 = -2 over the full 64-bit result
    do_check("s32_ok", 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 35, 1'b0, 1'b1);
    check_counts("s32_ok", 4, 0);

    // signed 16x16 with in_valid held through the check, then back-to-back accept
    do_check("s16_hold", 2'd2, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340,
             64'h0000_0000_0001_2340, 1'b1, 19, 1'b1, 1'b1);
    check_counts("s16_hold", 5, 0);
    do_check("s16_b2b", 2'd2, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340,
             64'h0000_0000_0001_2340, 1'b1, 19, 1'b0, 1'b1);
    check_counts("s16_b2b", 6, 0);

`ifdef CHK_HALT_ON_ERR_EN
    // first mismatch halts the checker
    do_check("s32_bad", 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0000_FFFF_FFFE,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 35, 1'b0, 1'b0);
    check_counts("s32_bad", 7, 1);
    bus.mode = 2'd0; bus.op_a = 32'd1; bus.op_b = 32'd1;
    bus.dut_product = 64'd1; bus.in_valid = 1'b1;
    dones = 0; readies = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
      if (bus.in_ready) readies++;
    end
    bus.in_valid = 1'b0;
    check("halt_ready", 64'(readies), 64'd0);
    check("halt_done", 64'(dones), 64'd0);
    check("halt_pass", 64'(bus.pass), 64'd0);
    check("halt_expected", bus.expected, 64'hFFFF_FFFF_FFFF_FFFE);
    check_counts("halt", 7, 1);
`else
    // mismatch (upper 32 bits missing) is counted and checking continues
    do_check("s32_bad", 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0000_FFFF_FFFE,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 35, 1'b0, 1'b1);
    check_counts("s32_bad", 7, 1);
    // correct low 16 bits but a stray bit above 2N must still fail
    do_check("u8_hi", 2'd0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0010_000F,
             64'h0000_0000_0000_000F, 1'b0, 11, 1'b0, 1'b1);
    check_counts("u8_hi", 8, 2);
    // garbage above the low 8 bits is ignored: 127 * -1 = -127
    do_check("s8_mask", 2'd1, 32'hABCD_EF7F, 32'h1234_56FF, 64'h0000_0000_0000_FF81,
             64'h0000_0000_0000_FF81, 1'b1, 11, 1'b0, 1'b1);
    check_counts("s8_mask", 9, 2);
`endif

    // reset during MUL cycle 5 of a 32x32 check
    bus.mode = 2'd3; bus.op_a = 32'h1234_5678; bus.op_b = 32'h8765_4321;
    bus.dut_product = 64'd0; bus.in_valid = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;  // clears any HALT so the tuple can be accepted
    #1;
    reset = 1'b1;
    @(posedge clock); #1;  // accept edge
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_pass", 64'(bus.pass), 64'd0);
    check("midrst_expected", bus.expected, 64'd0);
    check_counts("midrst", 0, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    dones = 0;
    repeat (45) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    check_counts("midrst_after", 0, 0);

    // checker works again after reset
    do_check("u8_post", 2'd0, 32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006,
             64'h0000_0000_0000_0006, 1'b1, 11, 1'b0, 1'b1);
    check_counts("u8_post", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
